// File: rtl/logic_unit_pkg.sv
// Shared encodings for the slice-sequential logic unit.
package logic_unit_pkg;

  localparam logic [1:0] LU_AND = 2'b00;
  localparam logic [1:0] LU_OR  = 2'b01;
  localparam logic [1:0] LU_XOR = 2'b10;
  localparam logic [1:0] LU_NOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } lu_state_e;

endpackage

// File: rtl/lane_logic.sv
// One LANE-bit slice of the bitwise operation; purely combinational.
module lane_logic
  import logic_unit_pkg::*;
#(
  parameter int unsigned LANE = 8
) (
  input  logic [1:0]      OP,
  input  logic [LANE-1:0] A,
  input  logic [LANE-1:0] B,
  output logic [LANE-1:0] Y
);

  // Select the bitwise function for this slice.
  always_comb begin
    Y = '0;
    case (OP)
      LU_AND:  Y = A & B;
      LU_OR:   Y = A | B;
      LU_XOR:  Y = A ^ B;
      default: Y = ~(A | B);
    endcase
  end

endmodule

// File: rtl/logic_unit_seq.sv
// Slice-sequential WIDTH-bit logic unit: LANE bits per clock behind a
// valid/ready handshake, with a ZERO flag for branch evaluation.
module logic_unit_seq
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LANE  = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Y,
  output logic             ZERO
);

  localparam int unsigned N  = (LANE > 0) ? WIDTH / LANE : 1;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (LANE < 1 || (WIDTH % ((LANE > 0) ? LANE : 1)) != 0) begin : g_param_check
    $error("logic_unit_seq: WIDTH must be a non-zero multiple of LANE");
  end

  lu_state_e        state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, y_q, y_d;
  logic [1:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             nz_q, nz_d, zero_q, zero_d;
  logic [LANE-1:0]  a_s, b_s, slice;
  logic             accept;

  assign IN_READY  = (state_q == IDLE) | ((state_q == DONE) & OUT_READY);
  assign accept    = IN_VALID & IN_READY;
  assign OUT_VALID = (state_q == DONE);
  assign Y         = y_q;
  assign ZERO      = zero_q;

  // Pick the operand slice addressed by the beat counter.
  always_comb begin
    a_s = '0;
    b_s = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (cnt_q == CW'(k)) begin
        a_s = a_q[k*LANE +: LANE];
        b_s = b_q[k*LANE +: LANE];
      end
    end
  end

  lane_logic #(.LANE(LANE)) u_lane (
    .OP (op_q),
    .A  (a_s),
    .B  (b_s),
    .Y  (slice)
  );

  // Next-state, beat datapath and operand capture.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    nz_d    = nz_q;
    y_d     = y_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: ;
      RUN: begin
        for (int unsigned k = 0; k < N; k++) begin
          if (cnt_q == CW'(k)) y_d[k*LANE +: LANE] = slice;
        end
        nz_d = nz_q | (|slice);
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          zero_d  = ~(nz_q | (|slice));
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: if (OUT_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Accept overrides the DONE->IDLE exit so back-to-back ops go straight to RUN.
    if (accept) begin
      state_d = RUN;
      a_d     = A;
      b_d     = B;
      op_d    = OP;
      cnt_d   = '0;
      nz_d    = 1'b0;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= LU_AND;
      cnt_q   <= '0;
      nz_q    <= 1'b0;
      y_q     <= '0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      nz_q    <= nz_d;
      y_q     <= y_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: tb/tb_logic_unit_seq.sv
// Bench for logic_unit_seq: 32/8 instance (main) and 16/16 instance (variant).
module tb_logic_unit_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  // 32-bit, 8-bit lane instance
  logic        iv, ir, ov, ordy, z;
  logic [1:0]  op;
  logic [31:0] a, b, y;
  // 16-bit, 16-bit lane instance
  logic        iv1, ir1, ov1, ordy1, z1;
  logic [1:0]  op1;
  logic [15:0] a1, b1, y1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  logic_unit_seq #(.WIDTH(32), .LANE(8)) dut (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(iv), .IN_READY(ir), .OP(op), .A(a), .B(b),
    .OUT_VALID(ov), .OUT_READY(ordy), .Y(y), .ZERO(z)
  );

  logic_unit_seq #(.WIDTH(16), .LANE(16)) dut1 (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(iv1), .IN_READY(ir1), .OP(op1), .A(a1), .B(b1),
    .OUT_VALID(ov1), .OUT_READY(ordy1), .Y(y1), .ZERO(z1)
  );

  // Reference: full-width bitwise function straight from the op table.
  function automatic logic [31:0] ref_y(input logic [1:0] o, input logic [31:0] x, input logic [31:0] w);
    case (o)
      2'd0:    return x & w;
      2'd1:    return x | w;
      2'd2:    return x ^ w;
      default: return ~(x | w);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op; if a result is pending, release it on the same edge.
  task automatic start_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] w);
    iv = 1'b1; op = o; a = x; b = w;
    ordy = ov;
    #1;
    chk({tag, "_in_ready"}, ir, 1);
    step();
    iv = 1'b0; ordy = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_result(input string tag, input logic [31:0] ey, input int exp_lat);
    int lat = 0;
    do begin
      step();
      lat++;
    end while (!ov && lat < 20);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_out_valid"}, ov, 1);
    chk({tag, "_y"}, y, ey);
    chk({tag, "_zero"}, z, (ey == 32'h0));
  endtask

  task automatic release_result(input string tag);
    ordy = 1'b1;
    step();
    ordy = 1'b0;
    chk({tag, "_released"}, ov, 0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb, ey;
    logic [15:0] s1, s2;
    logic        saw;
    int          lat;

    iv1 = 1'b0; op1 = 2'd0; a1 = '0; b1 = '0; ordy1 = 1'b0;

    // Reset with random inputs toggling
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      iv = 1'($urandom); op = 2'($urandom); a = $urandom; b = $urandom; ordy = 1'($urandom);
      step();
      chk("rst_out_valid", ov, 0);
      chk("rst_y", y, 0);
      chk("rst_zero", z, 1);
      chk("rst_in_ready", ir, 1);
    end
    chk("rst1_y", y1, 0);
    chk("rst1_zero", z1, 1);
    iv = 1'b0; ordy = 1'b0;
    rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      saw = saw | ov | ~ir;
    end
    chk("idle_after_reset", saw, 0);

    // Directed operations
    start_op("and", 2'd0, 32'hFFFF0000, 32'h0F0F0F0F);
    wait_result("and", 32'h0F0F0000, 4);
    release_result("and");
    start_op("xor", 2'd2, 32'hDEADBEEF, 32'hDEADBEEF);
    wait_result("xor", 32'h00000000, 4);
    release_result("xor");
    start_op("nor", 2'd3, 32'h00000000, 32'h00000000);
    wait_result("nor", 32'hFFFFFFFF, 4);
    release_result("nor");

    // Backpressure with a pending request, then back-to-back accept
    start_op("bp", 2'd0, 32'h12345678, 32'hF0F0F0F0);
    wait_result("bp", 32'h10305070, 4);
    iv = 1'b1; op = 2'd1; a = 32'h000000F0; b = 32'h00000F00;
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      saw = saw | ~ov | ir | (y != 32'h10305070) | z;
    end
    chk("bp_stable", saw, 0);
    ordy = 1'b1;
    #1;
    chk("bp_in_ready_comb", ir, 1);
    step();
    iv = 1'b0; ordy = 1'b0;
    op = 2'd0; a = '0; b = '0;
    chk("b2b_out_valid_low", ov, 0);
    wait_result("b2b_or", 32'h00000FF0, 4);
    release_result("b2b_or");

    // Reset asserted during beat 2
    start_op("midrst", 2'd1, 32'hA5A5A5A5, 32'h0000FFFF);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", ov, 0);
    chk("midrst_y", y, 0);
    chk("midrst_zero", z, 1);
    chk("midrst_in_ready", ir, 1);
    step();
    rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      saw = saw | ov;
    end
    chk("midrst_no_result", saw, 0);
    start_op("post_rst", 2'd2, 32'hCAFEF00D, 32'h0F0F0F0F);
    wait_result("post_rst", 32'hC5F1FF02, 4);
    release_result("post_rst");

    // Randomized ops, mixing released and back-to-back issue
    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ~ra;
        default: rb = $urandom;
      endcase
      ey = ref_y(ro, ra, rb);
      start_op("rnd", ro, ra, rb);
      wait_result("rnd", ey, 4);
      if ($urandom_range(0, 1) == 0) release_result("rnd");
    end
    if (ov) release_result("rnd_last");

    // 16-bit single-lane variant
    iv1 = 1'b1; op1 = 2'd1; a1 = 16'h8001; b1 = 16'h0002;
    step();
    iv1 = 1'b0; op1 = 2'd0; a1 = '0; b1 = '0;
    lat = 0;
    do begin step(); lat++; end while (!ov1 && lat < 20);
    chk("v16_latency", lat, 1);
    chk("v16_y", y1, 16'h8003);
    chk("v16_zero", z1, 0);
    ordy1 = 1'b1;
    step();
    ordy1 = 1'b0;
    chk("v16_released", ov1, 0);
    for (int i = 0; i < 6; i++) begin
      ro = 2'($urandom_range(0, 3));
      s1 = 16'($urandom);
      s2 = (i % 2 == 0) ? s1 : 16'($urandom);
      ey = ref_y(ro, {16'h0, s1}, {16'h0, s2});
      iv1 = 1'b1; op1 = ro; a1 = s1; b1 = s2;
      step();
      iv1 = 1'b0;
      lat = 0;
      do begin step(); lat++; end while (!ov1 && lat < 20);
      chk("v16_rnd_latency", lat, 1);
      chk("v16_rnd_y", y1, ey[15:0]);
      chk("v16_rnd_zero", z1, (ey[15:0] == 16'h0));
      ordy1 = 1'b1;
      step();
      ordy1 = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
